// File: rtl/mem_port_arbiter_if.sv
// Fetch/data request ports and the shared memory port of mem_port_arbiter.
// slave: arbiter view. master: requesters and memory model view.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_valid;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [31:0] dm_rdata;
   logic        dm_valid;
   logic        mem_en;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic        fetch_stall;
   logic        dm_stall;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_valid, dm_rdata, dm_valid, mem_en, mem_we, mem_addr, mem_wdata,
             fetch_stall, dm_stall
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_valid, dm_rdata, dm_valid, mem_en, mem_we, mem_addr, mem_wdata,
             fetch_stall, dm_stall
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access.
// Data wins ties. Define MEM_ARB_FAIR_EN to add a streak counter that grants
// fetch after STREAK_MAX consecutive data grants made while fetch was waiting.
module mem_port_arbiter #(
   parameter int unsigned STREAK_MAX = 4
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);

   localparam int unsigned DATA_W   = 32;
   localparam int unsigned STREAK_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic                grant_if;
   logic                grant_dm;
   logic                done_if;
   logic                done_dm;
   logic                fetch_first;

   logic                mem_en_q;
   logic                mem_we_q;
   logic [DATA_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic [DATA_W-1:0]   if_rdata_q;
   logic [DATA_W-1:0]   dm_rdata_q;
   logic                if_valid_q;
   logic                dm_valid_q;

   // Parameter range guard at elaboration
   if ((STREAK_MAX < 1) || (STREAK_MAX > 15)) begin : g_streak_range
      $error("mem_port_arbiter: STREAK_MAX must be within 1..15");
   end

`ifdef MEM_ARB_FAIR_EN
   logic [STREAK_W-1:0] streak_q;

   assign fetch_first = (streak_q == STREAK_W'(STREAK_MAX));

   // Count data grants made while fetch waits; any fetch grant or uncontested data grant clears
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         streak_q <= '0;
      end else if (grant_if) begin
         streak_q <= '0;
      end else if (grant_dm) begin
         if (!bus.if_req) begin
            streak_q <= '0;
         end else if (streak_q != STREAK_W'(STREAK_MAX)) begin
            streak_q <= streak_q + STREAK_W'(1);
         end
      end
   end
`else
   assign fetch_first = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: grant from IDLE, return to IDLE when memory completes
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.dm_req && !(bus.if_req && fetch_first)) begin
               state_d = BUSY_DM;
            end else if (bus.if_req) begin
               state_d = BUSY_IF;
            end
         end
         BUSY_IF, BUSY_DM: begin
            if (bus.mem_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode: grant and completion strobes for the datapath
   always_comb begin
      grant_if = 1'b0;
      grant_dm = 1'b0;
      done_if  = 1'b0;
      done_dm  = 1'b0;
      if (state_q == IDLE) begin
         grant_if = (state_d == BUSY_IF);
         grant_dm = (state_d == BUSY_DM);
      end
      if (bus.mem_ready) begin
         done_if = (state_q == BUSY_IF);
         done_dm = (state_q == BUSY_DM);
      end
   end

   // Memory port launch registers and read-data return registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         dm_valid_q  <= 1'b0;
      end else begin
         if_valid_q <= done_if;
         dm_valid_q <= done_dm;
         if (grant_if) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
         end else if (grant_dm) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.dm_we;
            mem_addr_q  <= bus.dm_addr;
            mem_wdata_q <= bus.dm_wdata;
         end else if (done_if || done_dm) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
         end
         if (done_if) begin
            if_rdata_q <= bus.mem_rdata;
         end
         // Stores leave the load-data register untouched
         if (done_dm && !mem_we_q) begin
            dm_rdata_q <= bus.mem_rdata;
         end
      end
   end

   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.if_valid  = if_valid_q;
   assign bus.dm_valid  = dm_valid_q;

   // Pipeline stalls release in the cycle the registered valid pulses
   assign bus.fetch_stall = bus.if_req & ~if_valid_q;
   assign bus.dm_stall    = bus.dm_req & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (fairness test adapts to MEM_ARB_FAIR_EN).
module tb_mem_port_arbiter;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;

   mem_port_arbiter_if bus ();

   mem_port_arbiter #(.STREAK_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.if_req = 1'b0; bus.if_addr = '0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
      bus.mem_rdata = '0; bus.mem_ready = 1'b0;
      #12;
      vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en got=%0b exp=0", bus.mem_en); end
      vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got=%0b exp=0", bus.mem_we); end
      vectors++; if (bus.mem_addr !== 32'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%h exp=0", bus.mem_addr); end
      vectors++; if (bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valids got=%0b%0b exp=00", bus.if_valid, bus.dm_valid); end
      vectors++; if (bus.if_rdata !== 32'h0 || bus.dm_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got=%h/%h exp=0/0", bus.if_rdata, bus.dm_rdata); end
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   task automatic test_fetch();
      bus.if_req = 1'b1; bus.if_addr = 32'h100;
      #1;
      vectors++; if (bus.fetch_stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_c1 got=%0b exp=1", bus.fetch_stall); end
      vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL fetch_en_c1 got=%0b exp=0", bus.mem_en); end
      tick();
      vectors++; if (bus.mem_en !== 1'b1) begin miscompares++; $display("FAIL fetch_en_c2 got=%0b exp=1", bus.mem_en); end
      vectors++; if (bus.mem_addr !== 32'h100) begin miscompares++; $display("FAIL fetch_addr got=%h exp=00000100", bus.mem_addr); end
      vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("FAIL fetch_we got=%0b exp=0", bus.mem_we); end
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h20010005;
      #1;
      vectors++; if (bus.fetch_stall !== 1'b1) begin miscompares++; $display("FAIL fetch_stall_c2 got=%0b exp=1", bus.fetch_stall); end
      tick();
      vectors++; if (bus.if_valid !== 1'b1) begin miscompares++; $display("FAIL fetch_valid_c3 got=%0b exp=1", bus.if_valid); end
      vectors++; if (bus.if_rdata !== 32'h20010005) begin miscompares++; $display("FAIL fetch_rdata got=%h exp=20010005", bus.if_rdata); end
      vectors++; if (bus.fetch_stall !== 1'b0) begin miscompares++; $display("FAIL fetch_stall_c3 got=%0b exp=0", bus.fetch_stall); end
      vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL fetch_en_c3 got=%0b exp=0", bus.mem_en); end
      bus.if_req = 1'b0; bus.mem_ready = 1'b0;
      tick();
      vectors++; if (bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL fetch_valid_c4 got=%0b exp=0", bus.if_valid); end
      vectors++; if (bus.if_rdata !== 32'h20010005) begin miscompares++; $display("FAIL fetch_rdata_hold got=%h exp=20010005", bus.if_rdata); end
   endtask

   task automatic test_tie();
      bus.if_req = 1'b1; bus.if_addr = 32'h200;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h400;
      tick();
      vectors++; if (bus.mem_addr !== 32'h400) begin miscompares++; $display("FAIL tie_first_addr got=%h exp=00000400", bus.mem_addr); end
      vectors++; if (bus.mem_en !== 1'b1) begin miscompares++; $display("FAIL tie_first_en got=%0b exp=1", bus.mem_en); end
      vectors++; if (bus.dm_stall !== 1'b1 || bus.fetch_stall !== 1'b1) begin miscompares++; $display("FAIL tie_stalls got=%0b%0b exp=11", bus.dm_stall, bus.fetch_stall); end
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11112222;
      tick();
      vectors++; if (bus.dm_valid !== 1'b1 || bus.if_valid !== 1'b0) begin miscompares++; $display("FAIL tie_dm_valid got=%0b%0b exp=10", bus.dm_valid, bus.if_valid); end
      vectors++; if (bus.dm_rdata !== 32'h11112222) begin miscompares++; $display("FAIL tie_dm_rdata got=%h exp=11112222", bus.dm_rdata); end
      vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL tie_idle_gap got=%0b exp=0", bus.mem_en); end
      bus.dm_req = 1'b0; bus.mem_ready = 1'b0;
      tick();
      vectors++; if (bus.mem_addr !== 32'h200 || bus.mem_en !== 1'b1) begin miscompares++; $display("FAIL tie_second_addr got=%h en=%0b exp=00000200 en=1", bus.mem_addr, bus.mem_en); end
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h33334444;
      tick();
      vectors++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'h33334444) begin miscompares++; $display("FAIL tie_if_done got=%0b/%h exp=1/33334444", bus.if_valid, bus.if_rdata); end
      bus.if_req = 1'b0; bus.mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_store();
      bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h80; bus.dm_wdata = 32'hDEADBEEF;
      tick();
      for (int i = 0; i < 6; i++) begin
         vectors++;
         if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_addr !== 32'h80) begin
            miscompares++;
            $display("FAIL store_hold cyc=%0d got en=%0b we=%0b wd=%h a=%h exp en=1 we=1 wd=deadbeef a=00000080", i, bus.mem_en, bus.mem_we, bus.mem_wdata, bus.mem_addr);
         end
         vectors++; if (bus.dm_valid !== 1'b0) begin miscompares++; $display("FAIL store_early_valid cyc=%0d got=%0b exp=0", i, bus.dm_valid); end
         bus.mem_ready = (i == 5);
         bus.mem_rdata = 32'hBAD0BAD0;
         tick();
      end
      vectors++; if (bus.dm_valid !== 1'b1) begin miscompares++; $display("FAIL store_valid got=%0b exp=1", bus.dm_valid); end
      vectors++; if (bus.dm_rdata !== 32'h11112222) begin miscompares++; $display("FAIL store_rdata_kept got=%h exp=11112222", bus.dm_rdata); end
      vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL store_en_drop got=%0b exp=0", bus.mem_en); end
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.mem_ready = 1'b0;
      tick();
      vectors++; if (bus.dm_valid !== 1'b0) begin miscompares++; $display("FAIL store_single_pulse got=%0b exp=0", bus.dm_valid); end
   endtask

   task automatic test_reset_mid_busy();
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h500;
      tick();
      vectors++; if (bus.mem_en !== 1'b1) begin miscompares++; $display("FAIL rst_pre_busy got=%0b exp=1", bus.mem_en); end
      #2;
      reset = 1'b0;
      #1;
      vectors++; if (bus.mem_en !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_we !== 1'b0 || bus.mem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_async_mem got en=%0b a=%h we=%0b wd=%h exp all 0", bus.mem_en, bus.mem_addr, bus.mem_we, bus.mem_wdata); end
      vectors++; if (bus.dm_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin miscompares++; $display("FAIL rst_async_rdata got=%h/%h exp=0/0", bus.dm_rdata, bus.if_rdata); end
      bus.dm_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE0000;
      tick();
      vectors++; if (bus.dm_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_valid_in got=%0b exp=0", bus.dm_valid); end
      reset = 1'b1; bus.mem_ready = 1'b0;
      tick();
      vectors++; if (bus.dm_valid !== 1'b0 || bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL rst_no_valid_after got=%0b en=%0b exp=0 en=0", bus.dm_valid, bus.mem_en); end
      bus.dm_req = 1'b1;
      tick();
      vectors++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h500) begin miscompares++; $display("FAIL rst_reissue_grant got en=%0b a=%h exp en=1 a=00000500", bus.mem_en, bus.mem_addr); end
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A5A0001;
      tick();
      vectors++; if (bus.dm_valid !== 1'b1 || bus.dm_rdata !== 32'h5A5A0001) begin miscompares++; $display("FAIL rst_reissue_done got=%0b/%h exp=1/5a5a0001", bus.dm_valid, bus.dm_rdata); end
      bus.dm_req = 1'b0; bus.mem_ready = 1'b0;
      tick();
   endtask

   task automatic test_idle_ready();
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         vectors++; if (bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0 || bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL idle_ready cyc=%0d got iv=%0b dv=%0b en=%0b exp 0 0 0", i, bus.if_valid, bus.dm_valid, bus.mem_en); end
      end
      vectors++; if (bus.dm_rdata !== 32'h5A5A0001 || bus.if_rdata !== 32'h0) begin miscompares++; $display("FAIL idle_ready_rdata got=%h/%h exp=5a5a0001/0", bus.dm_rdata, bus.if_rdata); end
      bus.mem_ready = 1'b0;
   endtask

   task automatic test_fairness();
      logic exp_fetch;
      bus.if_req = 1'b1; bus.if_addr = 32'h700;
      bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h600;
      for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_FAIR_EN
         exp_fetch = ((k % 5) == 4);
`else
         exp_fetch = 1'b0;
`endif
         tick();
         vectors++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== (exp_fetch ? 32'h700 : 32'h600)) begin miscompares++; $display("FAIL fair_grant k=%0d got en=%0b a=%h exp en=1 a=%h", k, bus.mem_en, bus.mem_addr, exp_fetch ? 32'h700 : 32'h600); end
         bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1000 + 32'(k);
         tick();
         vectors++; if (bus.if_valid !== exp_fetch || bus.dm_valid !== !exp_fetch) begin miscompares++; $display("FAIL fair_valid k=%0d got iv=%0b dv=%0b exp iv=%0b dv=%0b", k, bus.if_valid, bus.dm_valid, exp_fetch, !exp_fetch); end
         bus.mem_ready = 1'b0;
      end
`ifndef MEM_ARB_FAIR_EN
      vectors++; if (bus.fetch_stall !== 1'b1) begin miscompares++; $display("FAIL fair_starve got=%0b exp=1", bus.fetch_stall); end
`endif
      bus.if_req = 1'b0; bus.dm_req = 1'b0;
      tick();
      tick();
      vectors++; if (bus.mem_en !== 1'b0) begin miscompares++; $display("FAIL fair_drain got=%0b exp=0", bus.mem_en); end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      tick();
      test_fetch();
      test_tie();
      test_store();
      test_reset_mid_busy();
      test_idle_ready();
      test_fairness();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
